// File: rtl/matrix_pkg.sv
`default_nettype none
// ============================================================================
// Package  : matrix_pkg
// Purpose  : Shared constants, slot code table and FSM encoding for the
//            matrix row-scan sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package matrix_pkg;

    // Code that selects no line on the downstream decoder.
    localparam logic [2:0] BLANK_CODE = 3'b101;
    localparam int         NUM_SLOTS  = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHOW  = 2'b01,
        ST_BLANK = 2'b10
    } scan_state_t;

    // Select code driven while a given slot is shown. The blank code never
    // appears in this table.
    function automatic logic [2:0] slot_code(input logic [2:0] idx);
        logic [2:0] code;
        case (idx)
            3'd0:    code = 3'b000;
            3'd1:    code = 3'b001;
            3'd2:    code = 3'b011;
            3'd3:    code = 3'b010;
            3'd4:    code = 3'b100;
            3'd5:    code = 3'b110;
            3'd6:    code = 3'b111;
            default: code = BLANK_CODE;
        endcase
        return code;
    endfunction

    // Slot that follows idx; the last slot wraps back to slot 0.
    function automatic logic [2:0] next_slot(input logic [2:0] idx);
        return (idx == 3'(NUM_SLOTS - 1)) ? 3'd0 : idx + 3'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scan_timer.sv
`default_nettype none
// ============================================================================
// Module   : scan_timer
// Purpose  : Clearable up counter with a terminal-count flag. One instance
//            times both the slot dwell and the blanking gap; the caller picks
//            the terminal value for the phase it is in.
// Revision : 1.0 - initial release
// ============================================================================
module scan_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic [CNT_W-1:0] tc_val,
    output logic             tc
);

    logic [CNT_W-1:0] r_cnt;

    // Count register: clear wins over increment so a phase restarts at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tc = (r_cnt == tc_val);

endmodule
`default_nettype wire

// File: rtl/matrix_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : matrix_scan_ctrl
// Purpose  : Row-scan sequencer. Steps the 3-bit decoder select code through
//            seven slots with a programmable dwell, optionally separated by a
//            blanking gap, and emits slot/frame strobes for the column source.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_scan_ctrl
    import matrix_pkg::*;
#(
    parameter int DIV       = 250,
    parameter int BLANK_CYC = 8,
    parameter int CNT_W     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic       Ch2,
    output logic       Ch1,
    output logic       Ch0,
    output logic [2:0] slot,
    output logic       slot_strobe,
    output logic       frame_start
);

    localparam bit               C_HAS_BLANK = (BLANK_CYC > 0);
    localparam logic [CNT_W-1:0] C_SHOW_TC   = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] C_BLANK_TC  = C_HAS_BLANK ? CNT_W'(BLANK_CYC - 1) : '0;

    scan_state_t r_state;
    scan_state_t w_state_nxt;
    logic [2:0]  r_code;
    logic [2:0]  w_code_nxt;
    logic [2:0]  r_slot;
    logic [2:0]  w_slot_nxt;
    logic        r_slot_strobe;
    logic        w_slot_strobe_nxt;
    logic        r_frame_start;
    logic        w_frame_start_nxt;
    logic        w_tmr_clr;
    logic        w_tmr_inc;
    logic        w_tmr_tc;
    logic [2:0]  w_nslot;
    logic [CNT_W-1:0] w_tc_val;

    assign w_nslot  = next_slot(r_slot);
    assign w_tc_val = (r_state == ST_BLANK) ? C_BLANK_TC : C_SHOW_TC;

    scan_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (w_tmr_clr),
        .inc    (w_tmr_inc),
        .tc_val (w_tc_val),
        .tc     (w_tmr_tc)
    );

    // State and registered outputs; reset forces the blank/idle picture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_code        <= BLANK_CODE;
            r_slot        <= 3'd0;
            r_slot_strobe <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_code        <= w_code_nxt;
            r_slot        <= w_slot_nxt;
            r_slot_strobe <= w_slot_strobe_nxt;
            r_frame_start <= w_frame_start_nxt;
        end
    end

    // Next-state and next-output decode; strobes default low so they pulse.
    always_comb begin
        w_state_nxt       = r_state;
        w_code_nxt        = r_code;
        w_slot_nxt        = r_slot;
        w_slot_strobe_nxt = 1'b0;
        w_frame_start_nxt = 1'b0;
        w_tmr_clr         = 1'b0;
        w_tmr_inc         = 1'b0;

        if (!en) begin
            // Abandon whatever slot is in progress; no resume later.
            w_state_nxt = ST_IDLE;
            w_code_nxt  = BLANK_CODE;
            w_slot_nxt  = 3'd0;
            w_tmr_clr   = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt       = ST_SHOW;
                    w_slot_nxt        = 3'd0;
                    w_code_nxt        = slot_code(3'd0);
                    w_slot_strobe_nxt = 1'b1;
                    w_frame_start_nxt = 1'b1;
                    w_tmr_clr         = 1'b1;
                end
                ST_SHOW: begin
                    if (w_tmr_tc) begin
                        w_tmr_clr = 1'b1;
                        if (C_HAS_BLANK) begin
                            w_state_nxt = ST_BLANK;
                            w_code_nxt  = BLANK_CODE;
                        end else begin
                            w_state_nxt       = ST_SHOW;
                            w_slot_nxt        = w_nslot;
                            w_code_nxt        = slot_code(w_nslot);
                            w_slot_strobe_nxt = 1'b1;
                            w_frame_start_nxt = (w_nslot == 3'd0);
                        end
                    end else begin
                        w_tmr_inc = 1'b1;
                    end
                end
                ST_BLANK: begin
                    if (w_tmr_tc) begin
                        w_tmr_clr         = 1'b1;
                        w_state_nxt       = ST_SHOW;
                        w_slot_nxt        = w_nslot;
                        w_code_nxt        = slot_code(w_nslot);
                        w_slot_strobe_nxt = 1'b1;
                        w_frame_start_nxt = (w_nslot == 3'd0);
                    end else begin
                        w_tmr_inc = 1'b1;
                    end
                end
                default: begin
                    // Unused encoding: fall back to a clean idle.
                    w_state_nxt = ST_IDLE;
                    w_code_nxt  = BLANK_CODE;
                    w_slot_nxt  = 3'd0;
                    w_tmr_clr   = 1'b1;
                end
            endcase
        end
    end

    assign Ch2         = r_code[2];
    assign Ch1         = r_code[1];
    assign Ch0         = r_code[0];
    assign slot        = r_slot;
    assign slot_strobe = r_slot_strobe;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_matrix_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_scan_ctrl
// Purpose  : Self-checking bench for matrix_scan_ctrl. Instance A uses a
//            dwell of 4 with a 2-cycle blank; instance B uses a dwell of 1
//            with no blanking.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_scan_ctrl;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic [2:0] code;
        logic [2:0] slot;
        logic       ss;
        logic       fs;
    } vec_t;

    logic clk;
    logic rst_a, en_a, ch2_a, ch1_a, ch0_a, ss_a, fs_a;
    logic rst_b, en_b, ch2_b, ch1_b, ch0_b, ss_b, fs_b;
    logic [2:0] slot_a, slot_b;
    logic [2:0] code_a, code_b;

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;

    logic [2:0] seq_tb [7];
    vec_t vec_a [8];
    vec_t vec_b [12];

    assign code_a = {ch2_a, ch1_a, ch0_a};
    assign code_b = {ch2_b, ch1_b, ch0_b};

    matrix_scan_ctrl #(.DIV(4), .BLANK_CYC(2), .CNT_W(16)) u_dut_a (
        .clk         (clk),
        .rst_n       (rst_a),
        .en          (en_a),
        .Ch2         (ch2_a),
        .Ch1         (ch1_a),
        .Ch0         (ch0_a),
        .slot        (slot_a),
        .slot_strobe (ss_a),
        .frame_start (fs_a)
    );

    matrix_scan_ctrl #(.DIV(1), .BLANK_CYC(0), .CNT_W(16)) u_dut_b (
        .clk         (clk),
        .rst_n       (rst_b),
        .en          (en_b),
        .Ch2         (ch2_b),
        .Ch1         (ch1_b),
        .Ch0         (ch0_b),
        .slot        (slot_b),
        .slot_strobe (ss_b),
        .frame_start (fs_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string tag, input bit sel_b,
                             input logic [2:0] c, input logic [2:0] s,
                             input logic ss, input logic fs);
        if (!sel_b) begin
            chk({tag, ".code"},  {5'd0, code_a}, {5'd0, c});
            chk({tag, ".slot"},  {5'd0, slot_a}, {5'd0, s});
            chk({tag, ".sstrb"}, {7'd0, ss_a},   {7'd0, ss});
            chk({tag, ".frame"}, {7'd0, fs_a},   {7'd0, fs});
        end else begin
            chk({tag, ".code"},  {5'd0, code_b}, {5'd0, c});
            chk({tag, ".slot"},  {5'd0, slot_b}, {5'd0, s});
            chk({tag, ".sstrb"}, {7'd0, ss_b},   {7'd0, ss});
            chk({tag, ".frame"}, {7'd0, fs_b},   {7'd0, fs});
        end
    endtask

    // Expected A outputs k cycles after the first slot-0 strobe:
    // each slot is 4 show cycles then 2 blank cycles, 7 slots per frame.
    task automatic check_model_a(input string tag, input int k);
        int sl;
        int ph;
        logic [2:0] c;
        sl = (k / 6) % 7;
        ph = k % 6;
        c  = (ph < 4) ? seq_tb[sl] : 3'b101;
        check_out($sformatf("%s[k=%0d]", tag, k), 1'b0, c, 3'(sl), (ph == 0), (k % 42 == 0));
    endtask

    function automatic bit in_seq(input logic [2:0] c);
        bit hit = 1'b0;
        for (int i = 0; i < 7; i++) if (seq_tb[i] == c) hit = 1'b1;
        return hit || (c == 3'b101);
    endfunction

    function automatic logic [7:0] decode(input logic [2:0] c);
        return (c == 3'b101) ? 8'd0 : (8'd1 << c);
    endfunction

    // Invariants on both instances, sampled away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            total++;
            a_code_a: assert (in_seq(code_a)) else begin bad++; $display("FAIL inv_code_a: got %0b", code_a); end
            a_fs_a:   assert (!fs_a || ss_a) else begin bad++; $display("FAIL inv_frame_a: fs=%0b ss=%0b", fs_a, ss_a); end
            a_slot_a: assert (slot_a <= 3'd6) else begin bad++; $display("FAIL inv_slot_a: got %0d", slot_a); end
            a_dec_a:  assert ($onehot0(decode(code_a))) else begin bad++; $display("FAIL inv_dec_a: got %0b", decode(code_a)); end
            a_code_b: assert (in_seq(code_b)) else begin bad++; $display("FAIL inv_code_b: got %0b", code_b); end
            a_fs_b:   assert (!fs_b || ss_b) else begin bad++; $display("FAIL inv_frame_b: fs=%0b ss=%0b", fs_b, ss_b); end
            a_slot_b: assert (slot_b <= 3'd6) else begin bad++; $display("FAIL inv_slot_b: got %0d", slot_b); end
            a_dec_b:  assert ($onehot0(decode(code_b))) else begin bad++; $display("FAIL inv_dec_b: got %0b", decode(code_b)); end
        end
    end

    initial begin
        seq_tb = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b100, 3'b110, 3'b111};

        // A: reset with en high, release, first slot, blank, slot 1 strobe.
        vec_a[0] = '{1'b0, 1'b1, 3'b101, 3'd0, 1'b0, 1'b0};
        vec_a[1] = '{1'b1, 1'b1, 3'b000, 3'd0, 1'b1, 1'b1};
        vec_a[2] = '{1'b1, 1'b1, 3'b000, 3'd0, 1'b0, 1'b0};
        vec_a[3] = '{1'b1, 1'b1, 3'b000, 3'd0, 1'b0, 1'b0};
        vec_a[4] = '{1'b1, 1'b1, 3'b000, 3'd0, 1'b0, 1'b0};
        vec_a[5] = '{1'b1, 1'b1, 3'b101, 3'd0, 1'b0, 1'b0};
        vec_a[6] = '{1'b1, 1'b1, 3'b101, 3'd0, 1'b0, 1'b0};
        vec_a[7] = '{1'b1, 1'b1, 3'b001, 3'd1, 1'b1, 1'b0};

        // B: code advances every cycle, strobe always high, wrap, en drop.
        vec_b[0]  = '{1'b0, 1'b1, 3'b101, 3'd0, 1'b0, 1'b0};
        vec_b[1]  = '{1'b1, 1'b1, 3'b000, 3'd0, 1'b1, 1'b1};
        vec_b[2]  = '{1'b1, 1'b1, 3'b001, 3'd1, 1'b1, 1'b0};
        vec_b[3]  = '{1'b1, 1'b1, 3'b011, 3'd2, 1'b1, 1'b0};
        vec_b[4]  = '{1'b1, 1'b1, 3'b010, 3'd3, 1'b1, 1'b0};
        vec_b[5]  = '{1'b1, 1'b1, 3'b100, 3'd4, 1'b1, 1'b0};
        vec_b[6]  = '{1'b1, 1'b1, 3'b110, 3'd5, 1'b1, 1'b0};
        vec_b[7]  = '{1'b1, 1'b1, 3'b111, 3'd6, 1'b1, 1'b0};
        vec_b[8]  = '{1'b1, 1'b1, 3'b000, 3'd0, 1'b1, 1'b1};
        vec_b[9]  = '{1'b1, 1'b1, 3'b001, 3'd1, 1'b1, 1'b0};
        vec_b[10] = '{1'b1, 1'b0, 3'b101, 3'd0, 1'b0, 1'b0};
        vec_b[11] = '{1'b1, 1'b1, 3'b000, 3'd0, 1'b1, 1'b1};

        rst_a = 1'b0; en_a = 1'b1;
        rst_b = 1'b0; en_b = 1'b0;

        for (int i = 0; i < 8; i++) begin
            rst_a = vec_a[i].rst_n;
            en_a  = vec_a[i].en;
            step();
            started = 1'b1;
            check_out($sformatf("vec_a[%0d]", i), 1'b0, vec_a[i].code, vec_a[i].slot,
                      vec_a[i].ss, vec_a[i].fs);
        end

        // Free run two full frames and into the next, up to slot 3 show cycle 2.
        for (int k = 7; k <= 103; k++) begin
            step();
            check_model_a("run", k);
        end

        // Drop en mid-slot: idle immediately, held for 5 cycles.
        en_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_out($sformatf("en_low[%0d]", i), 1'b0, 3'b101, 3'd0, 1'b0, 1'b0);
        end

        // Re-enable: restart at slot 0 with a frame strobe, run into blank after slot 5.
        en_a = 1'b1;
        step();
        check_out("en_high", 1'b0, 3'b000, 3'd0, 1'b1, 1'b1);
        for (int k = 1; k <= 34; k++) begin
            step();
            check_model_a("rerun", k);
        end

        // One-cycle reset in the blank after slot 5 with en still high.
        rst_a = 1'b0;
        step();
        check_out("mid_rst", 1'b0, 3'b101, 3'd0, 1'b0, 1'b0);
        rst_a = 1'b1;
        step();
        check_out("post_rst", 1'b0, 3'b000, 3'd0, 1'b1, 1'b1);
        for (int k = 1; k <= 7; k++) begin
            step();
            check_model_a("post_rst_run", k);
        end

        for (int i = 0; i < 12; i++) begin
            rst_b = vec_b[i].rst_n;
            en_b  = vec_b[i].en;
            step();
            check_out($sformatf("vec_b[%0d]", i), 1'b1, vec_b[i].code, vec_b[i].slot,
                      vec_b[i].ss, vec_b[i].fs);
        end

        started = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
